// File: rtl/xpdma_arb_pkg.sv
// Shared types and default widths for the PCIe DMA to DDR3 command arbiter.
package xpdma_arb_pkg;

    // Arbiter FSM: wait for DDR calibration, pick a channel, present the
    // command, then hold off further grants until the burst completes.
    typedef enum logic [1:0] {
        ST_WAIT_RDY  = 2'd0,
        ST_IDLE      = 2'd1,
        ST_ISSUE     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_t;

    // Default command field widths.
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LEN_W  = 8;

endpackage

// File: rtl/xpdma_rr_pick.sv
// Combinational round-robin picker: the first requester found searching
// upward from last_ch+1, wrapping at NUM_CH, wins.
module xpdma_rr_pick
    import xpdma_arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] last_ch,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] grant_idx,
    output logic                      grant_any
);

    localparam int CH_W = $clog2(NUM_CH);

    // Scan the channels in priority order starting just after the last winner.
    always_comb begin
        int                cand;
        logic [CH_W-1:0]   cand_idx;
        // NOTE: every output gets a default before the loop so that no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 1; off <= NUM_CH; off++) begin
            cand     = (int'(last_ch) + off) % NUM_CH;
            cand_idx = CH_W'(cand);
            if (!grant_any && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
                grant_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xpdma_ddr_arbiter.sv
// Round-robin arbiter sharing the single DDR3 burst-command port among the
// PCIe DMA channels. One burst is outstanding at a time; stalled bursts raise
// a sticky timeout flag and bursts cut short by loss of ddr_rdy raise a sticky
// abort flag.
module xpdma_ddr_arbiter
    import xpdma_arb_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       pcie_clk_125MHz,
    input  logic                       pcie_rst,
    input  logic                       ddr_rdy,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*LEN_W-1:0]    req_len,
    output logic [NUM_CH-1:0]          req_ready,
    output logic                       cmd_valid,
    input  logic                       cmd_ready,
    output logic                       cmd_write,
    output logic [ADDR_W-1:0]          cmd_addr,
    output logic [LEN_W-1:0]           cmd_len,
    output logic [$clog2(NUM_CH)-1:0]  cmd_ch,
    input  logic                       done_valid,
    output logic                       busy,
    output logic                       timeout_err,
    output logic                       abort_err,
    output logic [$clog2(NUM_CH)-1:0]  err_ch
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    arb_state_t         state;
    arb_state_t         state_next;
    logic [CH_W-1:0]    last_ch;
    logic [CNT_W-1:0]   to_cnt;

    logic [NUM_CH-1:0]  pick_grant;
    logic [CH_W-1:0]    pick_idx;
    logic               pick_any;

    logic               accept;
    logic               handshake;
    logic               abort;
    logic               timeout_hit;

    xpdma_rr_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req       (req_valid),
        .last_ch   (last_ch),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // State register.
    always_ff @(posedge pcie_clk_125MHz) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (pcie_rst) state <= ST_WAIT_RDY;
        else          state <= state_next;
    end

    // Next-state and control strobes; loss of ddr_rdy overrides everything.
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        handshake   = 1'b0;
        abort       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_WAIT_RDY: begin
                if (ddr_rdy) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (!ddr_rdy) begin
                    state_next = ST_WAIT_RDY;
                end else if (pick_any) begin
                    accept     = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!ddr_rdy) begin
                    abort      = 1'b1;
                    state_next = ST_WAIT_RDY;
                end else if (cmd_ready) begin
                    handshake  = 1'b1;
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!ddr_rdy) begin
                    abort      = 1'b1;
                    state_next = ST_WAIT_RDY;
                end else if (done_valid) begin
                    // Completion on the final timeout cycle still counts.
                    state_next = ST_IDLE;
                end else if (to_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_WAIT_RDY;
        endcase
    end

    // Grant strobe is combinational so the winner sees it in its request cycle.
    assign req_ready = accept ? pick_grant : '0;
    assign cmd_valid = (state == ST_ISSUE);
    assign busy      = (state == ST_ISSUE) || (state == ST_WAIT_DONE);

    // Command capture, round-robin pointer, timeout counter and error flags.
    always_ff @(posedge pcie_clk_125MHz) begin
        if (pcie_rst) begin
            cmd_write   <= 1'b0;
            cmd_addr    <= '0;
            cmd_len     <= '0;
            cmd_ch      <= '0;
            last_ch     <= CH_W'(NUM_CH - 1);
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            abort_err   <= 1'b0;
            err_ch      <= '0;
        end else begin
            if (accept) begin
                cmd_write <= req_write[pick_idx];
                cmd_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
                cmd_len   <= req_len[pick_idx*LEN_W +: LEN_W];
                cmd_ch    <= pick_idx;
                last_ch   <= pick_idx;
            end

            // Saturating so a stuck count can never wrap back into range.
            if (handshake) begin
                to_cnt <= '0;
            end else if (state == ST_WAIT_DONE && to_cnt != CNT_SAT) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
                err_ch      <= cmd_ch;
            end
            if (abort) begin
                abort_err <= 1'b1;
                err_ch    <= cmd_ch;
            end
        end
    end

endmodule

// File: tb/tb_xpdma_ddr_arbiter.sv
// Self-checking bench for xpdma_ddr_arbiter: reset gating, a table of
// round-robin grants, hand-written timeout / collision / abort sequences and
// a randomized phase compared against a transaction-level reference model.
module tb_xpdma_ddr_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              ddr_rdy;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_write;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*LW-1:0] req_len;
    logic [NCH-1:0]    req_ready;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AW-1:0]     cmd_addr;
    logic [LW-1:0]     cmd_len;
    logic [1:0]        cmd_ch;
    logic              done_valid;
    logic              busy;
    logic              timeout_err;
    logic              abort_err;
    logic [1:0]        err_ch;

    int errors = 0;
    int checks = 0;

    xpdma_ddr_arbiter #(
        .NUM_CH         (NCH),
        .ADDR_W         (AW),
        .LEN_W          (LW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .pcie_clk_125MHz (clk),
        .pcie_rst        (rst),
        .ddr_rdy         (ddr_rdy),
        .req_valid       (req_valid),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_ready       (req_ready),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cmd_ch          (cmd_ch),
        .done_valid      (done_valid),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .abort_err       (abort_err),
        .err_ch          (err_ch)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] addr_of(int ch, int tag);
        return 32'h1000_0000 + AW'(tag << 8) + AW'(ch << 4);
    endfunction

    function automatic logic [LW-1:0] len_of(int ch, int tag);
        return LW'(tag * 4 + ch);
    endfunction

    function automatic logic wr_of(int ch, int tag);
        return 1'((ch + tag) % 2);
    endfunction

    function automatic int idx_of(logic [NCH-1:0] g);
        for (int i = 0; i < NCH; i++) if (g[i]) return i;
        return 0;
    endfunction

    // Round-robin rule: first requester above the last winner, wrapping.
    function automatic logic [NCH-1:0] rr_expect(logic [NCH-1:0] req, int last);
        for (int off = 1; off <= NCH; off++) begin
            int c = (last + off) % NCH;
            if (req[c]) return NCH'(1 << c);
        end
        return '0;
    endfunction

    task automatic load_channels(input int tag);
        for (int i = 0; i < NCH; i++) begin
            req_write[i]           = wr_of(i, tag);
            req_addr[i*AW +: AW]   = addr_of(i, tag);
            req_len[i*LW +: LW]    = len_of(i, tag);
        end
    endtask

    // Request from IDLE, check the grant and the presented command, then
    // hand it off after one stall cycle. Ends in the first WAIT_DONE cycle.
    task automatic accept(input logic [NCH-1:0] valid, input logic [NCH-1:0] exp_grant, input int tag);
        int ch;
        load_channels(tag);
        req_valid = valid;
        #2;
        check("grant", 64'(req_ready), 64'(exp_grant));
        tick();
        req_valid = '0;
        if (exp_grant == '0) begin
            #2;
            check("no_grant_busy", 64'(busy), 64'd0);
            check("no_grant_cmd_valid", 64'(cmd_valid), 64'd0);
            return;
        end
        ch = idx_of(exp_grant);
        #2;
        check("cmd_valid", 64'(cmd_valid), 64'd1);
        check("cmd_ch", 64'(cmd_ch), 64'(ch));
        check("cmd_addr", 64'(cmd_addr), 64'(addr_of(ch, tag)));
        check("cmd_len", 64'(cmd_len), 64'(len_of(ch, tag)));
        check("cmd_write", 64'(cmd_write), 64'(wr_of(ch, tag)));
        check("busy_issue", 64'(busy), 64'd1);
        tick();
        cmd_ready = 1'b1;
        #2;
        check("cmd_valid_held", 64'(cmd_valid), 64'd1);
        check("cmd_addr_held", 64'(cmd_addr), 64'(addr_of(ch, tag)));
        tick();
        cmd_ready = 1'b0;
        #2;
        check("busy_wait_done", 64'(busy), 64'd1);
        check("cmd_valid_after_hs", 64'(cmd_valid), 64'd0);
    endtask

    // From WAIT_DONE, pulse done_valid after 'delay' more cycles.
    task automatic finish_done(input int delay);
        repeat (delay) tick();
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        #2;
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [NCH-1:0] valid;
        logic [NCH-1:0] grant;
    } vec_t;

    typedef enum int { P_IDLE, P_ISSUE, P_WAIT } phase_t;

    initial begin
        vec_t           vecs[12];
        phase_t         ph;
        int             m_last;
        int             wait_left;
        int             cur_ch;
        logic [AW-1:0]  cur_addr;
        logic [LW-1:0]  cur_len;
        logic           cur_wr;
        logic [NCH-1:0] exp_rdy;

        // Grant order after reset (last winner = 3): full rotation, then
        // sparse patterns that exercise wrap-around and skipping.
        vecs[0]  = '{4'b1111, 4'b0001};
        vecs[1]  = '{4'b1111, 4'b0010};
        vecs[2]  = '{4'b1111, 4'b0100};
        vecs[3]  = '{4'b1111, 4'b1000};
        vecs[4]  = '{4'b1111, 4'b0001};
        vecs[5]  = '{4'b1010, 4'b0010};
        vecs[6]  = '{4'b1010, 4'b1000};
        vecs[7]  = '{4'b1010, 4'b0010};
        vecs[8]  = '{4'b0100, 4'b0100};
        vecs[9]  = '{4'b0001, 4'b0001};
        vecs[10] = '{4'b0000, 4'b0000};
        vecs[11] = '{4'b1000, 4'b1000};

        rst        = 1'b1;
        ddr_rdy    = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_addr   = '0;
        req_len    = '0;
        cmd_ready  = 1'b0;
        done_valid = 1'b0;

        // Reset values.
        tick();
        tick();
        #2;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_write", 64'(cmd_write), 64'd0);
        check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        check("rst_cmd_len", 64'(cmd_len), 64'd0);
        check("rst_cmd_ch", 64'(cmd_ch), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_abort_err", 64'(abort_err), 64'd0);
        check("rst_err_ch", 64'(err_ch), 64'd0);
        tick();
        rst = 1'b0;

        // Gating while DDR is not ready.
        req_valid = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            tick();
            #2;
            check("gate_req_ready", 64'(req_ready), 64'd0);
        end
        ddr_rdy = 1'b1;
        #2;
        check("rdy_rise_cycle_no_grant", 64'(req_ready), 64'd0);
        tick();

        // Table-driven grants; each burst completes 3 cycles after handshake.
        for (int r = 0; r < 12; r++) begin
            accept(vecs[r].valid, vecs[r].grant, r + 1);
            if (vecs[r].grant != '0) finish_done(2);
        end
        check("no_err_after_table", 64'({timeout_err, abort_err}), 64'd0);

        // Collision: done_valid on the last timeout cycle completes cleanly.
        accept(4'b0010, 4'b0010, 20);
        repeat (TO - 1) tick();
        done_valid = 1'b1;
        #2;
        check("collision_busy", 64'(busy), 64'd1);
        tick();
        done_valid = 1'b0;
        #2;
        check("collision_no_timeout", 64'(timeout_err), 64'd0);
        check("collision_idle", 64'(busy), 64'd0);

        // Timeout on channel 2: flag appears exactly TO edges after handshake.
        accept(4'b0100, 4'b0100, 21);
        repeat (TO - 1) tick();
        #2;
        check("timeout_not_early", 64'(timeout_err), 64'd0);
        check("timeout_busy_before", 64'(busy), 64'd1);
        tick();
        #2;
        check("timeout_err", 64'(timeout_err), 64'd1);
        check("timeout_err_ch", 64'(err_ch), 64'd2);
        check("timeout_busy_after", 64'(busy), 64'd0);
        check("timeout_no_abort", 64'(abort_err), 64'd0);
        accept(4'b0001, 4'b0001, 22);
        finish_done(0);

        // Abort during WAIT_DONE of a channel-1 burst.
        accept(4'b0010, 4'b0010, 23);
        ddr_rdy   = 1'b0;
        req_valid = 4'b1111;
        #2;
        check("abort_drop_cycle_busy", 64'(busy), 64'd1);
        check("abort_drop_cycle_no_grant", 64'(req_ready), 64'd0);
        tick();
        #2;
        check("abort_err", 64'(abort_err), 64'd1);
        check("abort_err_ch", 64'(err_ch), 64'd1);
        check("abort_cmd_valid", 64'(cmd_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_timeout_sticky", 64'(timeout_err), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            #2;
            check("abort_hold_no_grant", 64'(req_ready), 64'd0);
        end
        tick();
        ddr_rdy = 1'b1;
        #2;
        check("abort_rdy_rise_no_grant", 64'(req_ready), 64'd0);
        tick();
        accept(4'b1111, 4'b0100, 24);
        finish_done(1);

        // Randomized phase against a transaction-level model.
        m_last    = 2;
        ph        = P_IDLE;
        wait_left = 0;
        cur_ch    = 0;
        cur_addr  = '0;
        cur_len   = '0;
        cur_wr    = 1'b0;
        tick();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = NCH'($urandom_range(0, 15));
            for (int i = 0; i < NCH; i++) begin
                req_write[i]         = 1'($urandom_range(0, 1));
                req_addr[i*AW +: AW] = AW'($urandom);
                req_len[i*LW +: LW]  = LW'($urandom_range(0, 255));
            end
            cmd_ready  = 1'($urandom_range(0, 1));
            done_valid = (ph == P_WAIT) ? (wait_left == 0) : ($urandom_range(0, 3) == 0);
            #2;
            exp_rdy = (ph == P_IDLE) ? rr_expect(req_valid, m_last) : '0;
            check("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
            check("rnd_busy", 64'(busy), 64'(ph != P_IDLE));
            check("rnd_cmd_valid", 64'(cmd_valid), 64'(ph == P_ISSUE));
            if (ph == P_ISSUE) begin
                check("rnd_cmd_ch", 64'(cmd_ch), 64'(cur_ch));
                check("rnd_cmd_addr", 64'(cmd_addr), 64'(cur_addr));
                check("rnd_cmd_len", 64'(cmd_len), 64'(cur_len));
                check("rnd_cmd_write", 64'(cmd_write), 64'(cur_wr));
            end
            case (ph)
                P_IDLE: begin
                    if (exp_rdy != '0) begin
                        cur_ch   = idx_of(exp_rdy);
                        cur_addr = req_addr[cur_ch*AW +: AW];
                        cur_len  = req_len[cur_ch*LW +: LW];
                        cur_wr   = req_write[cur_ch];
                        m_last   = cur_ch;
                        ph       = P_ISSUE;
                    end
                end
                P_ISSUE: begin
                    if (cmd_ready) begin
                        wait_left = $urandom_range(0, 8);
                        ph        = P_WAIT;
                    end
                end
                default: begin
                    if (wait_left == 0) ph = P_IDLE;
                    else wait_left--;
                end
            endcase
            tick();
        end
        done_valid = 1'b0;
        cmd_ready  = 1'b0;
        req_valid  = '0;
        #2;
        check("rnd_err_ch_unchanged", 64'(err_ch), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
